// File: rtl/seg_scan_controller.sv
// seg_scan_controller
// Drives a 4-digit common-anode 7-segment display showing the cart bill total.
// Each digit is shown for one prescaler period. An all-off blanking gap
// separates consecutive digits to prevent ghosting.
// A new BCD value is latched only at a frame boundary, using a req/ack
// handshake. While the display is idle, a value can also be latched at any time.
//
// Handshake: the requester raises load_req with value_in stable and holds
// both until it sees load_ack. load_ack is a one-cycle pulse, asserted in the
// cycle after the edge that captured value_in. The requester must drop
// load_req in the cycle where it sees load_ack. Dropping load_req before
// load_ack withdraws the request, and nothing is latched.
module seg_scan_controller #(
  parameter int TICK_W    = 17,
  parameter int BLANK_CYC = 64,
  parameter int DP_DIGIT  = 2,
  parameter int LZ_BLANK  = 1
) (
  input  logic        mClk,
  input  logic        Reset,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load_req,
  output logic        load_ack,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  localparam int              BW         = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0]   BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [1:0]      DP_IDX     = 2'(DP_DIGIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_idx;
  logic [15:0]         r_disp;
  logic [TICK_W-1:0]   r_presc;
  logic [BW-1:0]       r_blank;
  logic                r_load_ack;
  logic                r_frame_done;
  logic [3:0]          r_an;
  logic [6:0]          r_seg;
  logic                r_dp;

  logic                w_blank_last;
  logic                w_boundary;
  logic                w_latch;
  logic [15:0]         w_disp_nxt;
  logic [1:0]          w_show_idx;
  logic [3:0]          w_digit;
  logic [3:0]          w_nz;
  logic                w_lz;
  logic [3:0]          w_an_nxt;
  logic [6:0]          w_seg_nxt;
  logic                w_dp_nxt;

  // Active-low segment patterns {g,f,e,d,c,b,a}. Non-decimal codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b0111111;
    endcase
    return p;
  endfunction

  // Compute the next-slot context.
  // The frame boundary is the BLANK exit after digit 3. A load latched on
  // that edge is displayed at once in the digit-0 slot that follows.
  always_comb begin
    w_blank_last = (r_blank == BLANK_LAST);
    w_boundary   = (r_state == S_BLANK) && enable && w_blank_last && (r_idx == 2'd3);
    // !r_load_ack in IDLE keeps load_ack a single pulse while the requester reacts.
    w_latch      = load_req && (((r_state == S_IDLE) && !r_load_ack) || w_boundary);
    w_disp_nxt   = w_latch ? value_in : r_disp;
    w_show_idx   = (r_state == S_BLANK) ? (r_idx + 2'd1) : 2'd0;
    w_digit      = w_disp_nxt[{w_show_idx, 2'b00} +: 4];
    w_nz         = {|w_disp_nxt[15:12], |w_disp_nxt[11:8], |w_disp_nxt[7:4], |w_disp_nxt[3:0]};
    // Blank a leading zero: the digit is above the decimal point, and it and all higher digits are zero.
    w_lz         = (LZ_BLANK != 0) && (w_show_idx > DP_IDX) && ((w_nz >> w_show_idx) == 4'd0);
    w_an_nxt     = w_lz ? 4'b1111 : ~(4'b0001 << w_show_idx);
    w_seg_nxt    = w_lz ? 7'h7F : decode(w_digit);
    w_dp_nxt     = w_lz || (w_show_idx != DP_IDX);
  end

  // Scan FSM. All display outputs are registered together with the state.
  always_ff @(posedge mClk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_disp       <= 16'h0000;
      r_presc      <= '0;
      r_blank      <= '0;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
      r_an         <= 4'b1111;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
    end else begin
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_latch) begin
            r_disp     <= value_in;
            r_load_ack <= 1'b1;
          end
          if (enable) begin
            r_state <= S_SHOW;
            r_idx   <= 2'd0;
            r_presc <= '0;
            r_blank <= '0;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
          end
        end
        S_SHOW: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_presc <= '0;
            r_blank <= '0;
            r_an    <= 4'b1111;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
          end else if (&r_presc) begin
            r_state <= S_BLANK;
            r_presc <= '0;
            r_blank <= '0;
            r_an    <= 4'b1111;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
          end else begin
            r_presc <= r_presc + TICK_W'(1);
          end
        end
        S_BLANK: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_presc <= '0;
            r_blank <= '0;
            r_an    <= 4'b1111;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
          end else if (w_blank_last) begin
            r_state <= S_SHOW;
            r_idx   <= r_idx + 2'd1;
            r_blank <= '0;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
            if (r_idx == 2'd3) begin
              r_frame_done <= 1'b1;
              if (w_latch) begin
                r_disp     <= value_in;
                r_load_ack <= 1'b1;
              end
            end
          end else begin
            r_blank <= r_blank + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= 2'd0;
          r_presc <= '0;
          r_blank <= '0;
          r_an    <= 4'b1111;
          r_seg   <= 7'h7F;
          r_dp    <= 1'b1;
        end
      endcase
    end
  end

  assign load_ack   = r_load_ack;
  assign frame_done = r_frame_done;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign dbg_state  = r_state;

endmodule
